pipe_sequencer: RTL and testbench
=================================

// Module: pipe_sequencer
// PURPOSE
//  Central stall/flush sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
//  Combines the load-use hazard flag, EX-stage branch redirect, a multi-cycle data-memory handshake and the syscall exit request.
//  Drives per-stage register enables and flushes, and halts the core cleanly after draining.
//  Keeps saturating stall and flush counters for performance reporting.
// PARAMETERS
//  CNT_W        32   width of perf counters stall_cnt / flush_cnt
//  DRAIN_CYC    2    cycles spent draining MEM/WB after halt request (fixed pipeline depth)
//  MEM_TMO      255  MEM_WAIT cycles before mem_timeout is raised (8-bit compare)
// PORTS
//  clk          in   1      core clock
//  rst          in   1      synchronous reset, active-high
//  lu           in   1      load-use hazard detected in ID (from hazard detector)
//  br_taken     in   1      branch/jump redirect resolved in EX this cycle
//  dmem_req     in   1      MEM stage issuing a data-memory access
//  dmem_ack     in   1      data memory completes access this cycle
//  halt_req     in   1      exit syscall present in EX
//  resume       in   1      restart from HALT (debug/console)
//  pc_en        out  1      PC register write enable
//  ifid_en      out  1      IF/ID enable;  idex_en / exmem_en / memwb_en likewise (3 ports, 1 bit each)
//  ifid_flush   out  1      IF/ID bubble insert;  idex_flush likewise
//  halted       out  1      core is in HALT
//  mem_timeout  out  1      sticky: memory wait exceeded MEM_TMO
//  stall_cnt    out  CNT_W  cycles with pc_en=0 outside HALT, saturating
//  flush_cnt    out  CNT_W  cycles with ifid_flush=1, saturating
// BEHAVIOUR
//  Interface: one clock clk; reset rst is synchronous, active-high.
//  States: RUN, MEM_WAIT, DRAIN, HALT. Reset -> RUN; counters, timeout, drain/wait counters = 0.
//  While rst=1: all *_en=0, flushes=1, halted=0. Enables/flushes are combinational from state+inputs (zero latency).
//  RUN priority (highest first):
//   1 dmem_req & !dmem_ack: all *_en=0, no flush; next MEM_WAIT.
//   2 halt_req: pc_en=0, ifid_flush=idex_flush=1, exmem_en=memwb_en=1; next DRAIN, drain counter=0.
//   3 br_taken: all en=1, ifid_flush=idex_flush=1 (lu ignored: its ID instr is squashed).
//   4 lu: pc_en=ifid_en=0, idex_flush=1, exmem_en=memwb_en=1 (one bubble).
//   5 else all en=1, no flush.
//  MEM_WAIT: all en=0 until dmem_ack; ack cycle behaves as RUN with dmem_ack=1 and returns to RUN.
//   Wait counter (8b) increments per MEM_WAIT cycle, saturating; reaching MEM_TMO sets mem_timeout (sticky until rst). State stays MEM_WAIT.
//   br_taken/halt_req/lu held by frozen stages, re-evaluated after ack.
//  DRAIN: pc_en=ifid_en=idex_en=0, exmem_en=memwb_en=1, idex_flush=1; DRAIN_CYC cycles then HALT.
//   dmem_req&!dmem_ack during DRAIN freezes all stages; drain counter holds.
//  HALT: all en=0, flushes=0, halted=1 (registered, asserted first HALT cycle). resume -> RUN next cycle.
//  Simultaneous resume+rst: rst wins. resume outside HALT ignored.
//  Counters: +1 per qualifying cycle, saturate at all-ones (no wrap); cleared only by rst.
// STRUCTURE
//  pipe_seq_defs.vh: state localparams (RUN=2'd0, MEM_WAIT=2'd1, DRAIN=2'd2, HALT=2'd3), enable-vector bit indices.
//  Sub-module sat_counter #(W): clk, rst, inc -> q, saturating; instanced for stall_cnt, flush_cnt, wait counter.
//  One registered state FSM + one combinational output decoder; no other storage.
// TESTING
//  lu=1 one cycle in RUN -> pc_en=ifid_en=0, idex_flush=1 that cycle; stall_cnt=1, flush_cnt=0.
//  br_taken=1 & lu=1 same cycle -> all en=1, ifid_flush=idex_flush=1; stall_cnt=0, flush_cnt=1.
//  dmem_req=1, ack after 4 cycles -> 4 frozen cycles (all en=0) then RUN; stall_cnt=4; no timeout.
//  dmem_req held 300 cycles, no ack -> mem_timeout=1 on the 255th wait cycle, stays 1 after ack until rst.
//  halt_req -> 2 DRAIN cycles (exmem_en=memwb_en=1) -> halted=1; resume -> RUN, pc_en=1 next cycle.
//  rst asserted in MEM_WAIT/DRAIN -> next cycle RUN, counters 0, mem_timeout=0, halted=0.

Source files
------------

// File: rtl/pipe_sequencer_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, stage-enable
// bit positions and the per-cycle control bundle driven to the pipeline.
package pipe_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    localparam int EN_PC    = 0;
    localparam int EN_IFID  = 1;
    localparam int EN_IDEX  = 2;
    localparam int EN_EXMEM = 3;
    localparam int EN_MEMWB = 4;
    localparam int EN_W     = 5;

    localparam logic [EN_W-1:0] EN_ALL  = 5'b11111;
    localparam logic [EN_W-1:0] EN_NONE = 5'b00000;
    localparam logic [EN_W-1:0] EN_BACK = 5'b11000;  // EX/MEM and MEM/WB only
    localparam logic [EN_W-1:0] EN_LU   = 5'b11100;  // hold PC and IF/ID, bubble into ID/EX

    typedef struct packed {
        logic [EN_W-1:0] en;
        logic            ifid_flush;
        logic            idex_flush;
    } ctrl_t;

    // Controls for an unfrozen RUN cycle; the memory stall is handled by the caller.
    function automatic ctrl_t run_decode(input logic halt_req, input logic br_taken,
                                         input logic lu);
        ctrl_t c;
        c = '{en: EN_ALL, ifid_flush: 1'b0, idex_flush: 1'b0};
        if (halt_req) begin
            c = '{en: EN_BACK, ifid_flush: 1'b1, idex_flush: 1'b1};
        end else if (br_taken) begin
            c = '{en: EN_ALL, ifid_flush: 1'b1, idex_flush: 1'b1};
        end else if (lu) begin
            c = '{en: EN_LU, ifid_flush: 1'b0, idex_flush: 1'b1};
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_sequencer_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_inc && (r_q != '1)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: per-stage enables and flushes,
// memory-wait freeze with sticky timeout, drain-then-halt, and perf counters.
module pipe_sequencer
    import pipe_sequencer_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int DRAIN_CYC = 2,
    parameter int MEM_TMO   = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_lu,
    input  logic             i_br_taken,
    input  logic             i_dmem_req,
    input  logic             i_dmem_ack,
    input  logic             i_halt_req,
    input  logic             i_resume,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_idex_en,
    output logic             o_exmem_en,
    output logic             o_memwb_en,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_halted,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DRAIN_W-1:0]   r_drain_cnt;
    logic [DRAIN_W-1:0]   w_drain_nxt;
    logic                 r_mem_timeout;
    ctrl_t                w_ctrl;
    logic [7:0]           w_wait_q;
    logic                 w_in_wait;
    logic                 w_tmo_hit;
    logic                 w_stall_inc;

    assign w_in_wait = (r_state == ST_MEM_WAIT);
    assign w_tmo_hit = w_in_wait && (w_wait_q == 8'(MEM_TMO - 1));

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_ctrl      = '{en: EN_NONE, ifid_flush: 1'b0, idex_flush: 1'b0};
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        if (i_rst) begin
            w_ctrl.ifid_flush = 1'b1;
            w_ctrl.idex_flush = 1'b1;
        end else begin
            case (r_state)
                ST_RUN, ST_MEM_WAIT: begin
                    // In MEM_WAIT the stalled request is frozen in MEM, so only ack matters.
                    if (!i_dmem_ack && (i_dmem_req || w_in_wait)) begin
                        w_state_nxt = ST_MEM_WAIT;
                    end else begin
                        w_ctrl      = run_decode(i_halt_req, i_br_taken, i_lu);
                        w_state_nxt = i_halt_req ? ST_DRAIN : ST_RUN;
                        w_drain_nxt = '0;
                    end
                end
                ST_DRAIN: begin
                    if (!(i_dmem_req && !i_dmem_ack)) begin
                        w_ctrl = '{en: EN_BACK, ifid_flush: 1'b0, idex_flush: 1'b1};
                        if (r_drain_cnt == DRAIN_W'(DRAIN_CYC - 1)) begin
                            w_state_nxt = ST_HALT;
                            w_drain_nxt = '0;
                        end else begin
                            w_drain_nxt = r_drain_cnt + 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    if (i_resume) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_RUN;
            r_drain_cnt   <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
            if (w_tmo_hit) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    assign w_stall_inc = !w_ctrl.en[EN_PC] && (r_state != ST_HALT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (w_stall_inc),
        .o_q   (o_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (w_ctrl.ifid_flush),
        .o_q   (o_flush_cnt)
    );

    // Wait counter restarts on every entry into MEM_WAIT.
    sat_counter #(.W(8)) u_wait_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst || !w_in_wait),
        .i_inc (w_in_wait),
        .o_q   (w_wait_q)
    );

    assign o_pc_en       = w_ctrl.en[EN_PC];
    assign o_ifid_en     = w_ctrl.en[EN_IFID];
    assign o_idex_en     = w_ctrl.en[EN_IDEX];
    assign o_exmem_en    = w_ctrl.en[EN_EXMEM];
    assign o_memwb_en    = w_ctrl.en[EN_MEMWB];
    assign o_ifid_flush  = w_ctrl.ifid_flush;
    assign o_idex_flush  = w_ctrl.idex_flush;
    assign o_halted      = (r_state == ST_HALT) && !i_rst;
    assign o_mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer: inputs change on the falling edge, outputs are
// sampled 1ns later; counters therefore show the totals of all preceding cycles.
module tb_pipe_sequencer;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1, i_lu = 1'b0, i_br_taken = 1'b0, i_dmem_req = 1'b0;
    logic        i_dmem_ack = 1'b0, i_halt_req = 1'b0, i_resume = 1'b0;
    logic        o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en;
    logic        o_ifid_flush, o_idex_flush, o_halted, o_mem_timeout;
    logic [31:0] o_stall_cnt, o_flush_cnt;
    logic [7:0]  w_obs;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, halted}
    assign w_obs = {o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en,
                    o_ifid_flush, o_idex_flush, o_halted};

    pipe_sequencer #(.CNT_W(32), .DRAIN_CYC(2), .MEM_TMO(255)) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_lu          (i_lu),
        .i_br_taken    (i_br_taken),
        .i_dmem_req    (i_dmem_req),
        .i_dmem_ack    (i_dmem_ack),
        .i_halt_req    (i_halt_req),
        .i_resume      (i_resume),
        .o_pc_en       (o_pc_en),
        .o_ifid_en     (o_ifid_en),
        .o_idex_en     (o_idex_en),
        .o_exmem_en    (o_exmem_en),
        .o_memwb_en    (o_memwb_en),
        .o_ifid_flush  (o_ifid_flush),
        .o_idex_flush  (o_idex_flush),
        .o_halted      (o_halted),
        .o_mem_timeout (o_mem_timeout),
        .o_stall_cnt   (o_stall_cnt),
        .o_flush_cnt   (o_flush_cnt)
    );

    task automatic drive(input logic rst, input logic lu, input logic br, input logic req,
                         input logic ack, input logic halt, input logic res);
        @(negedge clk);
        i_rst = rst; i_lu = lu; i_br_taken = br; i_dmem_req = req;
        i_dmem_ack = ack; i_halt_req = halt; i_resume = res;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (w_obs !== 8'b00000_11_0) begin
            errors++; $display("FAIL reset_outs got %b want %b", w_obs, 8'b00000_11_0);
        end
        idle();
        checks++;
        if (w_obs !== 8'b11111_00_0) begin
            errors++; $display("FAIL run_idle_outs got %b want %b", w_obs, 8'b11111_00_0);
        end
        checks++;
        if (o_stall_cnt !== 32'd0 || o_flush_cnt !== 32'd0 || o_mem_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_state got stall=%0d flush=%0d tmo=%b want 0 0 0",
                               o_stall_cnt, o_flush_cnt, o_mem_timeout);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (w_obs !== 8'b00111_01_0) begin
            errors++; $display("FAIL lu_outs got %b want %b", w_obs, 8'b00111_01_0);
        end
        idle();
        checks++;
        if (o_stall_cnt !== 32'd1 || o_flush_cnt !== 32'd0) begin
            errors++; $display("FAIL lu_cnts got stall=%0d flush=%0d want 1 0",
                               o_stall_cnt, o_flush_cnt);
        end
    endtask

    task automatic test_branch();
        do_reset();
        drive(0, 1, 1, 0, 0, 0, 0);
        checks++;
        if (w_obs !== 8'b11111_11_0) begin
            errors++; $display("FAIL br_lu_outs got %b want %b", w_obs, 8'b11111_11_0);
        end
        idle();
        checks++;
        if (o_stall_cnt !== 32'd0 || o_flush_cnt !== 32'd1) begin
            errors++; $display("FAIL br_cnts got stall=%0d flush=%0d want 0 1",
                               o_stall_cnt, o_flush_cnt);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 0, 0, 0);
            checks++;
            if (w_obs !== 8'b00000_00_0) begin
                errors++; $display("FAIL mem_freeze[%0d] got %b want %b", i, w_obs, 8'b00000_00_0);
            end
        end
        drive(0, 0, 0, 1, 1, 0, 0);
        checks++;
        if (w_obs !== 8'b11111_00_0) begin
            errors++; $display("FAIL mem_ack_outs got %b want %b", w_obs, 8'b11111_00_0);
        end
        idle();
        checks++;
        if (o_stall_cnt !== 32'd4 || o_mem_timeout !== 1'b0 || w_obs !== 8'b11111_00_0) begin
            errors++; $display("FAIL mem_after got stall=%0d tmo=%b outs=%b want 4 0 11111000",
                               o_stall_cnt, o_mem_timeout, w_obs);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        // drive 1 is the RUN cycle; drive k (k>=2) is MEM_WAIT cycle k-1
        for (int k = 1; k <= 300; k++) begin
            drive(0, 0, 0, 1, 0, 0, 0);
            if (k == 254) begin
                checks++;
                if (o_mem_timeout !== 1'b0) begin
                    errors++; $display("FAIL tmo_early got %b want 0", o_mem_timeout);
                end
            end
            if (k == 257) begin
                checks++;
                if (o_mem_timeout !== 1'b1) begin
                    errors++; $display("FAIL tmo_raised got %b want 1", o_mem_timeout);
                end
            end
        end
        drive(0, 0, 0, 1, 1, 0, 0);
        checks++;
        if (w_obs !== 8'b11111_00_0 || o_stall_cnt !== 32'd300) begin
            errors++; $display("FAIL tmo_ack got outs=%b stall=%0d want 11111000 300",
                               w_obs, o_stall_cnt);
        end
        idle();
        idle();
        checks++;
        if (o_mem_timeout !== 1'b1) begin
            errors++; $display("FAIL tmo_sticky got %b want 1", o_mem_timeout);
        end
        do_reset();
        idle();
        checks++;
        if (o_mem_timeout !== 1'b0 || o_stall_cnt !== 32'd0) begin
            errors++; $display("FAIL tmo_cleared got tmo=%b stall=%0d want 0 0",
                               o_mem_timeout, o_stall_cnt);
        end
    endtask

    task automatic test_halt();
        logic [7:0] exp_seq [5];
        exp_seq = '{8'b00011_11_0, 8'b00011_01_0, 8'b00011_01_0, 8'b00000_00_1, 8'b00000_00_1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            // halt_req only in the first cycle; resume in the second HALT cycle
            drive(0, 0, 0, 0, 0, (i == 0), (i == 4));
            checks++;
            if (w_obs !== exp_seq[i]) begin
                errors++; $display("FAIL halt_seq[%0d] got %b want %b", i, w_obs, exp_seq[i]);
            end
        end
        idle();
        checks++;
        if (w_obs !== 8'b11111_00_0 || o_stall_cnt !== 32'd3 || o_flush_cnt !== 32'd1) begin
            errors++; $display("FAIL resume got outs=%b stall=%0d flush=%0d want 11111000 3 1",
                               w_obs, o_stall_cnt, o_flush_cnt);
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (w_obs !== 8'b11111_00_0) begin
            errors++; $display("FAIL resume_in_run got %b want %b", w_obs, 8'b11111_00_0);
        end
    endtask

    task automatic test_drain_freeze();
        logic [7:0] exp_seq [5];
        exp_seq = '{8'b00011_11_0, 8'b00000_00_0, 8'b00011_01_0, 8'b00011_01_0, 8'b00000_00_1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, (i == 1), 0, (i == 0), 0);
            checks++;
            if (w_obs !== exp_seq[i]) begin
                errors++; $display("FAIL drain_frz[%0d] got %b want %b", i, w_obs, exp_seq[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_seq [6];
        exp_seq = '{8'b00000_00_0, 8'b00000_00_0, 8'b00011_11_0,
                    8'b00011_01_0, 8'b00011_01_0, 8'b00000_00_1};
        do_reset();
        // halt_req held by frozen stages through the wait, accepted on the ack cycle
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, (i < 3), (i == 2), (i < 3), 0);
            checks++;
            if (w_obs !== exp_seq[i]) begin
                errors++; $display("FAIL wait_halt[%0d] got %b want %b", i, w_obs, exp_seq[i]);
            end
        end
        idle();
        checks++;
        if (o_halted !== 1'b1 || o_stall_cnt !== 32'd5 || o_flush_cnt !== 32'd1) begin
            errors++; $display("FAIL wait_halt_cnts got halted=%b stall=%0d flush=%0d want 1 5 1",
                               o_halted, o_stall_cnt, o_flush_cnt);
        end
        drive(1, 0, 0, 0, 0, 0, 1);
        checks++;
        if (w_obs !== 8'b00000_11_0) begin
            errors++; $display("FAIL rst_resume got %b want %b", w_obs, 8'b00000_11_0);
        end
        idle();
        checks++;
        if (w_obs !== 8'b11111_00_0 || o_stall_cnt !== 32'd0) begin
            errors++; $display("FAIL after_rst_halt got outs=%b stall=%0d want 11111000 0",
                               w_obs, o_stall_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        do_reset();
        idle();
        checks++;
        if (w_obs !== 8'b11111_00_0 || o_stall_cnt !== 32'd0 || o_flush_cnt !== 32'd0) begin
            errors++; $display("FAIL rst_in_wait got outs=%b stall=%0d flush=%0d want 11111000 0 0",
                               w_obs, o_stall_cnt, o_flush_cnt);
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        idle();
        do_reset();
        idle();
        checks++;
        if (w_obs !== 8'b11111_00_0 || o_stall_cnt !== 32'd0 || o_flush_cnt !== 32'd0) begin
            errors++; $display("FAIL rst_in_drain got outs=%b stall=%0d flush=%0d want 11111000 0 0",
                               w_obs, o_stall_cnt, o_flush_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_halt();
        test_drain_freeze();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
